// File: rtl/bp_be_issue_queue_if.sv
// FE-to-BE instruction buffer bundle: enqueue side, issue side and pointer controls.
// slave is the queue; master is whoever drives fetch/dispatch/commit.
interface bp_be_issue_queue_if #(
   parameter int els_p         = 8,
   parameter int vaddr_width_p = 39,
   parameter int instr_width_p = 32
);
   localparam int ptr_width_lp = $clog2(els_p) + 1;

   logic                     fe_v_i;
   logic [vaddr_width_p-1:0] fe_pc_i;
   logic [instr_width_p-1:0] fe_instr_i;
   logic                     fe_ready_o;

   logic                     issue_v_o;
   logic [vaddr_width_p-1:0] issue_pc_o;
   logic [instr_width_p-1:0] issue_instr_o;

   logic                     dispatch_v_i;
   logic                     commit_v_i;
   logic                     roll_i;
   logic                     clr_i;

   logic                     full_o;
   logic                     empty_o;
   logic [ptr_width_lp-1:0]  count_o;

   modport slave (
      input  fe_v_i, fe_pc_i, fe_instr_i, dispatch_v_i, commit_v_i, roll_i, clr_i,
      output fe_ready_o, issue_v_o, issue_pc_o, issue_instr_o, full_o, empty_o, count_o
   );

   modport master (
      output fe_v_i, fe_pc_i, fe_instr_i, dispatch_v_i, commit_v_i, roll_i, clr_i,
      input  fe_ready_o, issue_v_o, issue_pc_o, issue_instr_o, full_o, empty_o, count_o
   );
endinterface

// File: rtl/bp_be_issue_queue.sv
// Circular instruction buffer with separate write, speculative read and commit pointers.
// Space is only reclaimed on commit, so a roll can always rewind the read pointer to cptr.
module bp_be_issue_queue #(
   parameter int els_p         = 8,
   parameter int vaddr_width_p = 39,
   parameter int instr_width_p = 32
) (
   input logic              clk_i,
   input logic              reset_n_i,
   bp_be_issue_queue_if.slave q
);
   localparam int idx_w_lp     = $clog2(els_p);
   localparam int ptr_width_lp = idx_w_lp + 1;

   typedef struct packed {
      logic [vaddr_width_p-1:0] pc;
      logic [instr_width_p-1:0] instr;
   } entry_s;

   entry_s                  mem [els_p];
   logic [ptr_width_lp-1:0] wptr_r, rptr_r, cptr_r;
   logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;
   logic                    full, issue_v, fe_ready;
   logic                    enq, deq, cmt;

   // Full when indices match but the wrap bits differ.
   assign full     = (wptr_r[idx_w_lp] != cptr_r[idx_w_lp]) &&
                     (wptr_r[idx_w_lp-1:0] == cptr_r[idx_w_lp-1:0]);
   assign issue_v  = (rptr_r != wptr_r);
   assign fe_ready = ~full & ~q.clr_i;

   assign enq = q.fe_v_i & fe_ready;
   assign deq = q.dispatch_v_i & issue_v & ~q.roll_i & ~q.clr_i;
   // An illegal commit (nothing dispatched) is dropped rather than corrupting cptr.
   assign cmt = q.commit_v_i & ~q.clr_i & (cptr_r != rptr_r);

   assign q.fe_ready_o    = fe_ready;
   assign q.issue_v_o     = issue_v;
   assign q.issue_pc_o    = mem[rptr_r[idx_w_lp-1:0]].pc;
   assign q.issue_instr_o = mem[rptr_r[idx_w_lp-1:0]].instr;
   assign q.full_o        = full;
   assign q.empty_o       = (cptr_r == wptr_r);
   assign q.count_o       = wptr_r - cptr_r;

   always_comb begin
      wptr_n = wptr_r;
      rptr_n = rptr_r;
      cptr_n = cptr_r;
      if (cmt) cptr_n = cptr_r + ptr_width_lp'(1);
      if (enq) wptr_n = wptr_r + ptr_width_lp'(1);
      // Roll rewinds to the post-commit cptr; a same-cycle dispatch is lost.
      if (q.roll_i)  rptr_n = cptr_n;
      else if (deq)  rptr_n = rptr_r + ptr_width_lp'(1);
      if (q.clr_i) begin
         wptr_n = '0;
         rptr_n = '0;
         cptr_n = '0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wptr_r <= '0;
         rptr_r <= '0;
         cptr_r <= '0;
      end else begin
         wptr_r <= wptr_n;
         rptr_r <= rptr_n;
         cptr_r <= cptr_n;
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) mem[wptr_r[idx_w_lp-1:0]] <= '{pc: q.fe_pc_i, instr: q.fe_instr_i};
   end

`ifndef SYNTHESIS
   a_dispatch_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (q.dispatch_v_i & ~q.clr_i) |-> issue_v);
   a_commit_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (q.commit_v_i & ~q.clr_i) |-> (cptr_r != rptr_r));
`endif
endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Issue queue bench: vector table, corner sequences and random traffic vs a list-based model.
module tb_bp_be_issue_queue;
   localparam int ELS = 8;
   localparam int VW  = 39;
   localparam int IW  = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bp_be_issue_queue_if #(.els_p(ELS), .vaddr_width_p(VW), .instr_width_p(IW)) q ();
   bp_be_issue_queue #(.els_p(ELS), .vaddr_width_p(VW), .instr_width_p(IW)) dut (
      .clk_i(clk), .reset_n_i(rst_n), .q(q)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Model: list of resident entries (oldest first) plus number dispatched-not-committed.
   typedef struct { logic [VW-1:0] pc; logic [IW-1:0] instr; } ent_t;
   ent_t mq[$];
   int   nd = 0;

   typedef struct {
      bit fv; logic [VW-1:0] pc; bit dv; bit cv; bit rv; bit clv;
      bit ev; logic [VW-1:0] epc; int ecnt; bit efull; bit eempty;
   } vec_t;
   vec_t tbl[15];

   function automatic logic [IW-1:0] instr_of(input logic [VW-1:0] pc);
      return pc[IW-1:0] ^ 32'hA5A5_0F0F;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      q.fe_v_i = 1'b0; q.fe_pc_i = '0; q.fe_instr_i = '0;
      q.dispatch_v_i = 1'b0; q.commit_v_i = 1'b0; q.roll_i = 1'b0; q.clr_i = 1'b0;
   endtask

   task automatic model_check(input string tag);
      bit mv;
      mv = (mq.size() > nd);
      chk({tag, " issue_v"}, 64'(q.issue_v_o), 64'(mv));
      if (mv) begin
         chk({tag, " pc"},    64'(q.issue_pc_o),    64'(mq[nd].pc));
         chk({tag, " instr"}, 64'(q.issue_instr_o), 64'(mq[nd].instr));
      end
      chk({tag, " count"}, 64'(q.count_o), 64'(mq.size()));
      chk({tag, " full"},  64'(q.full_o),  64'(mq.size() == ELS));
      chk({tag, " empty"}, 64'(q.empty_o), 64'(mq.size() == 0));
   endtask

   // Drive one cycle of inputs, check ready before the edge, update model, check after.
   task automatic step(input bit fv, input logic [VW-1:0] pc, input bit dv, input bit cv,
                       input bit rv, input bit clv, input string tag);
      bit mready, dok;
      q.fe_v_i = fv; q.fe_pc_i = pc; q.fe_instr_i = instr_of(pc);
      q.dispatch_v_i = dv; q.commit_v_i = cv; q.roll_i = rv; q.clr_i = clv;
      #1;
      mready = (mq.size() != ELS) && !clv;
      chk({tag, " ready"}, 64'(q.fe_ready_o), 64'(mready));
      @(posedge clk);
      if (clv) begin
         mq.delete();
         nd = 0;
      end else begin
         dok = dv && (mq.size() > nd);
         if (cv && nd > 0) begin
            void'(mq.pop_front());
            nd--;
         end
         if (rv) nd = 0;
         else if (dok) nd++;
         if (fv && mready) mq.push_back('{pc, instr_of(pc)});
      end
      #1;
      idle();
      #1;
      model_check(tag);
   endtask

   initial begin
      //            fv pc        dv cv rv cl  ev epc       cnt full empty
      tbl[0]  = '{1, 39'h2000, 0, 0, 0, 0,  1, 39'h2000, 1, 0, 0};
      tbl[1]  = '{1, 39'h2004, 1, 0, 0, 0,  1, 39'h2004, 2, 0, 0};
      tbl[2]  = '{1, 39'h2008, 1, 0, 0, 0,  1, 39'h2008, 3, 0, 0};
      tbl[3]  = '{1, 39'h200C, 1, 0, 0, 0,  1, 39'h200C, 4, 0, 0};
      tbl[4]  = '{1, 39'h2010, 1, 0, 0, 0,  1, 39'h2010, 5, 0, 0};
      tbl[5]  = '{0, 39'h0,    0, 1, 0, 0,  1, 39'h2010, 4, 0, 0};
      tbl[6]  = '{0, 39'h0,    0, 0, 1, 0,  1, 39'h2004, 4, 0, 0};
      tbl[7]  = '{0, 39'h0,    1, 0, 0, 0,  1, 39'h2008, 4, 0, 0};
      tbl[8]  = '{0, 39'h0,    1, 0, 0, 0,  1, 39'h200C, 4, 0, 0};
      tbl[9]  = '{0, 39'h0,    1, 0, 0, 0,  1, 39'h2010, 4, 0, 0};
      // commit + roll + dispatch + enqueue: one retires, one lands, rptr back to cptr
      tbl[10] = '{1, 39'h2014, 1, 1, 1, 0,  1, 39'h2008, 4, 0, 0};
      tbl[11] = '{1, 39'h3000, 0, 0, 0, 1,  0, 39'h0,    0, 0, 1};
      tbl[12] = '{1, 39'h3004, 0, 0, 0, 0,  1, 39'h3004, 1, 0, 0};
      tbl[13] = '{0, 39'h0,    1, 0, 0, 0,  0, 39'h0,    1, 0, 0};
      tbl[14] = '{0, 39'h0,    0, 1, 0, 0,  0, 39'h0,    0, 0, 1};

      idle();
      #12;
      chk("reset issue_v", 64'(q.issue_v_o),  64'(0));
      chk("reset empty",   64'(q.empty_o),    64'(1));
      chk("reset full",    64'(q.full_o),     64'(0));
      chk("reset count",   64'(q.count_o),    64'(0));
      chk("reset ready",   64'(q.fe_ready_o), 64'(1));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #2;

      for (int i = 0; i < 15; i++) begin
         step(tbl[i].fv, tbl[i].pc, tbl[i].dv, tbl[i].cv, tbl[i].rv, tbl[i].clv, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d exp_v", i), 64'(q.issue_v_o), 64'(tbl[i].ev));
         if (tbl[i].ev) chk($sformatf("vec%0d exp_pc", i), 64'(q.issue_pc_o), 64'(tbl[i].epc));
         chk($sformatf("vec%0d exp_cnt", i),   64'(q.count_o), 64'(tbl[i].ecnt));
         chk($sformatf("vec%0d exp_full", i),  64'(q.full_o),  64'(tbl[i].efull));
         chk($sformatf("vec%0d exp_empty", i), 64'(q.empty_o), 64'(tbl[i].eempty));
      end

      // Fill to 8, then drain with commit trailing dispatch by one cycle
      for (int i = 0; i < ELS; i++) step(1'b1, 39'h1000 + 39'(4 * i), 0, 0, 0, 0, "fill");
      chk("fill full",  64'(q.full_o),     64'(1));
      chk("fill ready", 64'(q.fe_ready_o), 64'(0));
      chk("fill count", 64'(q.count_o),    64'(8));
      for (int i = 0; i <= ELS; i++) begin
         if (i < ELS) chk("drain pc", 64'(q.issue_pc_o), 64'(39'h1000 + 39'(4 * i)));
         step(1'b0, '0, i < ELS, i > 0, 0, 0, "drain");
      end
      chk("drain empty", 64'(q.empty_o), 64'(1));

      // Single-slot wrap through index 7 -> 0 several times
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 39'h4000 + 39'(4 * i), 0, 0, 0, 0, "wrap enq");
         chk("wrap pc",  64'(q.issue_pc_o),   64'(39'h4000 + 39'(4 * i)));
         chk("wrap cnt", 64'(q.count_o <= 1), 64'(1));
         step(1'b0, '0, 1, 0, 0, 0, "wrap disp");
         step(1'b0, '0, 0, 1, 0, 0, "wrap cmt");
         chk("wrap cnt0", 64'(q.count_o), 64'(0));
      end

      // Clear with 6 entries and a same-cycle enqueue that must be refused
      for (int i = 0; i < 6; i++) step(1'b1, 39'h5000 + 39'(4 * i), 0, 0, 0, 0, "clr fill");
      step(1'b1, 39'h5FFC, 0, 0, 0, 1, "clr");
      chk("clr issue_v", 64'(q.issue_v_o), 64'(0));
      chk("clr empty",   64'(q.empty_o),   64'(1));
      chk("clr count",   64'(q.count_o),   64'(0));
      step(1'b1, 39'h5100, 0, 0, 0, 0, "post clr");
      chk("post clr pc", 64'(q.issue_pc_o), 64'(39'h5100));

      // Asynchronous reset between edges with 4 entries held
      for (int i = 0; i < 3; i++) step(1'b1, 39'h6100 + 39'(4 * i), 0, 0, 0, 0, "arst fill");
      chk("arst pre count", 64'(q.count_o), 64'(4));
      #2 rst_n = 1'b0;
      #1;
      chk("arst issue_v", 64'(q.issue_v_o), 64'(0));
      chk("arst count",   64'(q.count_o),   64'(0));
      chk("arst empty",   64'(q.empty_o),   64'(1));
      mq.delete();
      nd = 0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #2;
      step(1'b1, 39'h6000, 0, 0, 0, 0, "arst enq");
      chk("arst first v",  64'(q.issue_v_o),  64'(1));
      chk("arst first pc", 64'(q.issue_pc_o), 64'(39'h6000));

      // Random legal traffic against the model
      for (int i = 0; i < 600; i++) begin
         bit fv, dv, cv, rv, clv;
         logic [VW-1:0] pc;
         fv  = ($urandom_range(0, 3) != 0);
         pc  = VW'({$urandom(), $urandom()});
         dv  = (mq.size() > nd) && ($urandom_range(0, 1) == 1);
         cv  = (nd > 0) && ($urandom_range(0, 2) == 0);
         rv  = ($urandom_range(0, 15) == 0);
         clv = ($urandom_range(0, 59) == 0);
         step(fv, pc, dv, cv, rv, clv, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
